// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and multi-cycle instruction fetch initiator
// Holds imem_addr for WAIT_CYCLES edges, captures imem_ins, hands it to IF/ID under stall.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] PC_STEP     = 16'd2,
  parameter int          WAIT_CYCLES = 6
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_ins,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus,
  output logic        fetch_busy
);

  localparam int CW = $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0]   pc, pc_n;
  logic          capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      cnt        <= '0;
      pc         <= RESET_PC;
      if_instr   <= '0;
      if_pc      <= '0;
      if_pc_plus <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pc    <= pc_n;
      if (capture) begin
        if_instr   <= imem_ins;
        if_pc      <= pc;
        if_pc_plus <= pc + PC_STEP;
      end
    end
  end

  // A redirect overrides both the capture edge and a pending consume.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pc_n    = pc;
    capture = 1'b0;
    if (branch_taken) begin
      pc_n    = branch_target;
      cnt_n   = '0;
      state_n = FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (cnt == CNT_LAST) begin
            capture = 1'b1;
            cnt_n   = '0;
            state_n = HOLD;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        HOLD: begin
          if (!stall) begin
            pc_n    = pc + PC_STEP;
            cnt_n   = '0;
            state_n = FETCH;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  assign imem_addr  = pc;
  assign if_valid   = (state == HOLD);
  assign fetch_busy = (state == FETCH);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed table-driven bench for instr_fetch_unit
// Memory model: 5-stage delay of (mem_base + addr); two DUTs, second with RESET_PC=16'hFFFE.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken;
  logic [15:0] branch_target, imem_addr, imem_ins, if_instr, if_pc, if_pc_plus;
  logic        if_valid, fetch_busy;

  logic        rst_w, stall_w, branch_taken_w;
  logic [15:0] branch_target_w, imem_addr_w, imem_ins_w, if_instr_w, if_pc_w, if_pc_plus_w;
  logic        if_valid_w, fetch_busy_w;

  logic [15:0] mem_base;
  logic [15:0] p0 [5];
  logic [15:0] p1 [5];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_ins(imem_ins), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus(if_pc_plus), .fetch_busy(fetch_busy)
  );

  instr_fetch_unit #(.RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .rst(rst_w), .imem_addr(imem_addr_w), .imem_ins(imem_ins_w), .stall(stall_w),
    .branch_taken(branch_taken_w), .branch_target(branch_target_w), .if_valid(if_valid_w),
    .if_instr(if_instr_w), .if_pc(if_pc_w), .if_pc_plus(if_pc_plus_w), .fetch_busy(fetch_busy_w)
  );

  always @(posedge clk) begin
    p0[0] <= mem_base + imem_addr;
    p1[0] <= mem_base + imem_addr_w;
    for (int i = 1; i < 5; i++) begin
      p0[i] <= p0[i-1];
      p1[i] <= p1[i-1];
    end
  end
  assign imem_ins   = p0[4];
  assign imem_ins_w = p1[4];

  typedef struct {
    logic        rst, stall, br;
    logic [15:0] tgt;
    logic        e_valid, e_busy;
    logic [15:0] e_addr;
    logic        chk_d;
    logic [15:0] e_instr, e_pc, e_plus;
  } vec_t;

  vec_t vt [11];

  function automatic vec_t mk(logic r, logic s, logic b, logic [15:0] t, logic v, logic bz,
                              logic [15:0] a, logic cd, logic [15:0] ins, logic [15:0] p,
                              logic [15:0] pp);
    vec_t x;
    x.rst = r; x.stall = s; x.br = b; x.tgt = t; x.e_valid = v; x.e_busy = bz;
    x.e_addr = a; x.chk_d = cd; x.e_instr = ins; x.e_pc = p; x.e_plus = pp;
    return x;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n-1 edges with no valid, then the capture edge with full data check.
  task automatic expect_capture(input string name, input int n, input logic [15:0] pc,
                                input logic [15:0] ins, input bit w);
    logic [15:0] plus;
    plus = pc + 16'd2;
    for (int i = 1; i < n; i++) begin
      tick();
      chk1($sformatf("%s_wait%0d", name, i), w ? if_valid_w : if_valid, 1'b0);
    end
    tick();
    chk1({name, "_valid"}, w ? if_valid_w : if_valid, 1'b1);
    chk16({name, "_instr"}, w ? if_instr_w : if_instr, ins);
    chk16({name, "_pc"}, w ? if_pc_w : if_pc, pc);
    chk16({name, "_plus"}, w ? if_pc_plus_w : if_pc_plus, plus);
  endtask

  int          pcyc [8];
  logic [15:0] ppc  [8];
  logic [15:0] pins [8];
  logic        vhist [42];
  int          npulse;
  logic        prev;

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
    rst_w = 1'b1; stall_w = 1'b0; branch_taken_w = 1'b0; branch_target_w = 16'h0;
    mem_base = 16'h1234;

    vt[0]  = mk(1, 0, 0, 16'h0,  0, 1, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000);
    vt[1]  = mk(1, 0, 0, 16'h0,  0, 1, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000);
    vt[2]  = mk(0, 0, 0, 16'h0,  0, 1, 16'h0000, 0, 16'h0,    16'h0,    16'h0);
    vt[3]  = mk(0, 0, 0, 16'h0,  0, 1, 16'h0000, 0, 16'h0,    16'h0,    16'h0);
    vt[4]  = mk(0, 0, 0, 16'h0,  0, 1, 16'h0000, 0, 16'h0,    16'h0,    16'h0);
    vt[5]  = mk(0, 0, 0, 16'h0,  0, 1, 16'h0000, 0, 16'h0,    16'h0,    16'h0);
    vt[6]  = mk(0, 1, 0, 16'h0,  0, 1, 16'h0000, 0, 16'h0,    16'h0,    16'h0);
    vt[7]  = mk(0, 1, 0, 16'h0,  1, 0, 16'h0000, 1, 16'h1234, 16'h0000, 16'h0002);
    vt[8]  = mk(0, 1, 0, 16'h0,  1, 0, 16'h0000, 1, 16'h1234, 16'h0000, 16'h0002);
    vt[9]  = mk(0, 0, 0, 16'h0,  0, 1, 16'h0002, 0, 16'h0,    16'h0,    16'h0);
    vt[10] = mk(0, 0, 1, 16'h10, 0, 1, 16'h0010, 0, 16'h0,    16'h0,    16'h0);

    for (int i = 0; i < 11; i++) begin
      rst = vt[i].rst; stall = vt[i].stall;
      branch_taken = vt[i].br; branch_target = vt[i].tgt;
      tick();
      chk1($sformatf("v%0d_valid", i), if_valid, vt[i].e_valid);
      chk1($sformatf("v%0d_busy", i), fetch_busy, vt[i].e_busy);
      chk16($sformatf("v%0d_addr", i), imem_addr, vt[i].e_addr);
      if (vt[i].chk_d) begin
        chk16($sformatf("v%0d_instr", i), if_instr, vt[i].e_instr);
        chk16($sformatf("v%0d_pc", i), if_pc, vt[i].e_pc);
        chk16($sformatf("v%0d_plus", i), if_pc_plus, vt[i].e_plus);
      end
    end
    branch_taken = 1'b0;

    // Sequential stream, never stalled
    mem_base = 16'hA000; stall = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    npulse = 0; prev = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      vhist[c] = if_valid;
      if (if_valid && !prev && npulse < 8) begin
        pcyc[npulse] = c; ppc[npulse] = if_pc; pins[npulse] = if_instr;
        npulse++;
      end
      prev = if_valid;
    end
    chk16("seq_npulse", 16'(npulse), 16'd5);
    for (int k = 0; k < 4; k++) begin
      if (k < npulse) begin
        chk16($sformatf("seq%0d_cycle", k), 16'(pcyc[k]), 16'(6 + 7 * k));
        chk16($sformatf("seq%0d_pc", k), ppc[k], 16'(2 * k));
        chk16($sformatf("seq%0d_instr", k), pins[k], 16'hA000 + 16'(2 * k));
        chk1($sformatf("seq%0d_width", k), vhist[pcyc[k] + 1], 1'b0);
      end
    end

    // Stall holds the instruction and the address
    rst = 1'b1; stall = 1'b1;
    tick(); tick();
    rst = 1'b0;
    expect_capture("stall_cap", 6, 16'h0000, 16'hA000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1($sformatf("stall%0d_valid", i), if_valid, 1'b1);
      chk16($sformatf("stall%0d_instr", i), if_instr, 16'hA000);
      chk16($sformatf("stall%0d_pc", i), if_pc, 16'h0000);
      chk16($sformatf("stall%0d_addr", i), imem_addr, 16'h0000);
    end
    stall = 1'b0;
    tick();
    chk16("unstall_addr", imem_addr, 16'h0002);
    chk1("unstall_valid", if_valid, 1'b0);

    // Branch at edge 3 of the fetch at addr 4
    expect_capture("a2_cap", 6, 16'h0002, 16'hA002, 1'b0);
    tick();
    chk16("a4_addr", imem_addr, 16'h0004);
    tick(); tick();
    branch_taken = 1'b1; branch_target = 16'h0040;
    tick();
    branch_taken = 1'b0; stall = 1'b1;
    chk16("brmid_addr", imem_addr, 16'h0040);
    chk1("brmid_valid", if_valid, 1'b0);
    chk1("brmid_busy", fetch_busy, 1'b1);
    expect_capture("brmid_cap", 6, 16'h0040, 16'hA040, 1'b0);

    // Branch on the capture edge discards the capture
    stall = 1'b0;
    tick();
    stall = 1'b1;
    chk16("a42_addr", imem_addr, 16'h0042);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk1($sformatf("brcap_wait%0d", i), if_valid, 1'b0);
    end
    branch_taken = 1'b1; branch_target = 16'h0080;
    tick();
    branch_taken = 1'b0;
    chk1("brcap_valid", if_valid, 1'b0);
    chk16("brcap_addr", imem_addr, 16'h0080);
    expect_capture("brcap_cap", 6, 16'h0080, 16'hA080, 1'b0);

    // Branch during HOLD with stall asserted
    branch_taken = 1'b1; branch_target = 16'h0100;
    tick();
    branch_taken = 1'b0;
    chk1("brhold_valid", if_valid, 1'b0);
    chk16("brhold_addr", imem_addr, 16'h0100);
    expect_capture("brhold_cap", 6, 16'h0100, 16'hA100, 1'b0);

    // Branch to the current pc restarts the full wait
    stall = 1'b0;
    tick();
    stall = 1'b1;
    tick(); tick(); tick();
    branch_taken = 1'b1; branch_target = 16'h0102;
    tick();
    branch_taken = 1'b0;
    chk16("brsame_addr", imem_addr, 16'h0102);
    chk1("brsame_valid", if_valid, 1'b0);
    expect_capture("brsame_cap", 6, 16'h0102, 16'hA102, 1'b0);

    // Back-to-back branches: last target wins
    branch_taken = 1'b1; branch_target = 16'h0200;
    tick();
    branch_target = 16'h0300;
    tick();
    branch_taken = 1'b0;
    chk16("brb2b_addr", imem_addr, 16'h0300);
    expect_capture("brb2b_cap", 6, 16'h0300, 16'hA300, 1'b0);

    // Wrap and mid-fetch reset on the RESET_PC=FFFE instance
    stall_w = 1'b0;
    tick(); tick();
    rst_w = 1'b0;
    expect_capture("wrap_cap", 6, 16'hFFFE, 16'h9FFE, 1'b1);
    chk16("wrap_plus", if_pc_plus_w, 16'h0000);
    tick();
    chk16("wrap_addr", imem_addr_w, 16'h0000);
    tick(); tick();
    rst_w = 1'b1;
    tick();
    rst_w = 1'b0;
    chk16("rstmid_addr", imem_addr_w, 16'hFFFE);
    chk1("rstmid_valid", if_valid_w, 1'b0);
    chk1("rstmid_busy", fetch_busy_w, 1'b1);
    expect_capture("rstmid_cap", 6, 16'hFFFE, 16'h9FFE, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
